test_value_uart_tx: RTL
=======================

# test_value_uart_tx

Serial reporter that sits directly downstream of the MIPS top level. It consumes the processor's 16-bit `test_value` output and transmits it as ASCII text over a single UART TX line whenever the value changes. Each report is four uppercase hex characters followed by CR and LF, so a bench or lab terminal can log program results without probing internal buses.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Must be ≥ 2.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `test_value`  in  16  value to report; driven by the MIPS top level and may glitch.
- `tx`  out  1  UART line, 8N1, idle high.
- `busy`  out  1  high while a frame is being transmitted.
- `frame_count`  out  8  number of completed frames; wraps modulo 256.

## Operation
- Stability filter: register `s_q` captures `test_value` every cycle. A value qualifies only when `test_value == s_q`, i.e. it is identical on two consecutive edges.
- Trigger: in IDLE, a frame starts when the value qualifies and either it differs from `last_sent` or the `first` flag is set. On trigger, `last_sent` captures the value, `first` clears, and the 16-bit value is latched for the whole frame.
- Frame: 6 bytes, sent in this order:
  - hex(v[15:12]), hex(v[11:8]), hex(v[7:4]), hex(v[3:0]), 0x0D, 0x0A.
  - hex(n) is 0x30+n for n ≤ 9 and 0x37+n for n ≥ 10 (uppercase 'A'–'F').
- Byte format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly `CLKS_PER_BIT` cycles.
- FSM states:
  - IDLE → START on trigger.
  - START → DATA after one bit time.
  - DATA → STOP after 8 bit times.
  - STOP → START for the next byte (no inter-byte gap), or → IDLE after byte 5.
- Byte index is 3 bits (0..5); bit index is 3 bits; the bit-time counter counts 0..CLKS_PER_BIT−1.
- Changes to `test_value` during a frame are ignored by the frame in progress. After the frame ends, IDLE re-evaluates the current value, so only the latest stable value is sent and intermediate values are dropped.
- `frame_count` increments by 1 when the stop bit of byte 5 completes; 255 wraps to 0.
- Reset (asynchronous, mid-frame included) forces:
  - state = IDLE, `tx` = 1, `busy` = 0, `frame_count` = 0;
  - `last_sent` = 0, `s_q` = 0, `first` = 1.
  - Any frame in progress is aborted with no partial completion. The first qualifying value after release is always sent, even if it is 0x0000.

## Timing
- Reset values: `tx` = 1, `busy` = 0, `frame_count` = 0.
- Latency:
  - If trigger is evaluated true at edge k, then `tx` = 0 and `busy` = 1 from edge k onward.
  - A new `test_value` applied just before edge j qualifies at edge j+1, so `tx` falls at edge j+1.
- Frame length: exactly 60·`CLKS_PER_BIT` cycles from `tx` falling to the end of the last stop bit.
- `busy` falls and `frame_count` updates on the same edge at which the final stop bit ends.
- Earliest next start bit: the edge after `busy` falls (minimum one idle cycle between frames).
- `tx` is driven directly from a register, so it is glitch-free.

## Test plan
All scenarios use `CLKS_PER_BIT` = 4, giving 240 cycles per frame.
- Release reset with `test_value` = 16'h00A5 held → `tx` carries 0x30, 0x30, 0x41, 0x35, 0x0D, 0x0A; `busy` is high for 240 cycles; `frame_count` = 1.
- Same value held for 2000 further cycles → no new frame; `tx` stays 1; `frame_count` stays 1.
- Change to 16'hBEEF at cycle 50 of a frame, then to 16'h1234 at cycle 100 → the current frame completes unchanged; the next frame is "1234\r\n" (0x31, 0x32, 0x33, 0x34, 0x0D, 0x0A); "BEEF" is never sent.
- One-cycle glitch from 16'h00A5 to 16'hFFFF and back while IDLE → no frame; `frame_count` unchanged.
- Assert reset during data bit 3 of byte 2 → `tx` = 1, `busy` = 0, `frame_count` = 0 immediately without waiting for a clock; after release with the same value held, the full frame is resent and `frame_count` = 1.
- Alternate between two values for 257 frames → `frame_count` reads 255 then 0 then 1; every frame is bit-exact.

Source files
------------

// File: rtl/test_value_uart_tx_if.sv
// Bundle between the MIPS top level and its serial test-value reporter.
// Latency: none (wires only).
// Backpressure: none; the reporter samples test_value freely and drives the UART side.
interface test_value_uart_tx_if;
   logic [15:0] test_value;
   logic        tx;
   logic        busy;
   logic [7:0]  frame_count;

   // Drives the value to be reported and observes the UART side.
   modport master (
      output test_value,
      input  tx,
      input  busy,
      input  frame_count
   );

   // The reporter itself.
   modport slave (
      input  test_value,
      output tx,
      output busy,
      output frame_count
   );
endinterface

// File: rtl/test_value_uart_tx.sv
// Reports each new stable 16-bit test_value as "HHHH\r\n" over an 8N1 UART line.
// Latency: tx falls on the edge after the value has been seen on two consecutive edges; 60*CLKS_PER_BIT cycles per frame.
// Backpressure: none; changes during a frame are ignored and only the latest stable value is sent afterwards.
module test_value_uart_tx #(
   parameter int CLKS_PER_BIT = 16
) (
   input logic              CLK,
   input logic              reset,
   test_value_uart_tx_if.slave bus
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic [1:0]    state;
   logic [15:0]   s_q;
   logic [15:0]   last_sent;
   logic [15:0]   val_q;
   logic          first;
   logic [2:0]    byte_idx;
   logic [2:0]    bit_idx;
   logic [CW-1:0] clk_cnt;
   logic [7:0]    shreg;
   logic          tx_q;
   logic          busy_q;
   logic [7:0]    fc_q;

   logic          qualify;
   logic          trigger;
   logic          bit_done;
   logic [7:0]    cur_byte;

   // Uppercase ASCII hex digit for one nibble.
   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // Trigger and bit-timing decode; cur_byte is the character at byte_idx of the latched value.
   always_comb begin
      qualify  = (bus.test_value == s_q);
      trigger  = qualify && ((bus.test_value != last_sent) || first);
      bit_done = (clk_cnt == BIT_LAST);
      cur_byte = 8'h0A;
      case (byte_idx)
         3'd0:    cur_byte = hex_char(val_q[15:12]);
         3'd1:    cur_byte = hex_char(val_q[11:8]);
         3'd2:    cur_byte = hex_char(val_q[7:4]);
         3'd3:    cur_byte = hex_char(val_q[3:0]);
         3'd4:    cur_byte = 8'h0D;
         default: cur_byte = 8'h0A;
      endcase
   end

   // One-cycle delayed copy of test_value for the glitch filter.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) s_q <= 16'h0000;
      else        s_q <= bus.test_value;
   end

   // Frame sequencer; tx is a register output so the line never glitches.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         last_sent <= 16'h0000;
         val_q     <= 16'h0000;
         first     <= 1'b1;
         byte_idx  <= 3'd0;
         bit_idx   <= 3'd0;
         clk_cnt   <= '0;
         shreg     <= 8'h00;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         fc_q      <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (trigger) begin
                  state     <= START;
                  tx_q      <= 1'b0;
                  busy_q    <= 1'b1;
                  clk_cnt   <= '0;
                  byte_idx  <= 3'd0;
                  val_q     <= bus.test_value;
                  last_sent <= bus.test_value;
                  first     <= 1'b0;
               end
            end
            START: begin
               if (bit_done) begin
                  clk_cnt <= '0;
                  state   <= DATA;
                  bit_idx <= 3'd0;
                  tx_q    <= cur_byte[0];
                  shreg   <= {1'b0, cur_byte[7:1]};
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_done) begin
                  clk_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                     tx_q  <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx_q    <= shreg[0];
                     shreg   <= {1'b0, shreg[7:1]};
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_done) begin
                  clk_cnt <= '0;
                  if (byte_idx == 3'd5) begin
                     // Last stop bit done: back to IDLE, which re-evaluates on the next edge.
                     state  <= IDLE;
                     busy_q <= 1'b0;
                     fc_q   <= fc_q + 8'd1;
                  end else begin
                     byte_idx <= byte_idx + 3'd1;
                     state    <= START;
                     tx_q     <= 1'b0;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.tx          = tx_q;
   assign bus.busy        = busy_q;
   assign bus.frame_count = fc_q;

endmodule
